ddr2_init_sequencer: RTL and testbench

Power-up and initialization sequencer for the DDR2 memory interface. It enables the differential memory clock driver, holds CKE low through the power-up wait, then issues the JEDEC DDR2 initialization command sequence (precharge, extended/mode register loads, DLL reset, refreshes, OCD calibration). It asserts `init_done` when the device is ready. It sits between the clock infrastructure IOBs and the command/address IOBs, and owns the command bus until `init_done`.

---
 rtl/ddr2_init_pkg.sv | 48 ++++
 rtl/ddr2_init_timer.sv | 29 ++
 rtl/ddr2_init_sequencer.sv | 170 +++++++++++++++++
 tb/tb_ddr2_init_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ddr2_init_pkg.sv
// Shared types and constants for the DDR2 power-up / initialization sequencer.
package ddr2_init_pkg;

  // Sequencer states. ST_RESET is held only while rst_n is low and for the
  // cycle after release; it is the point from which ck_en is raised.
  typedef enum logic [3:0] {
    ST_RESET     = 4'd0,
    ST_PWRUP     = 4'd1,
    ST_CKE_WAIT  = 4'd2,
    ST_PRE1      = 4'd3,
    ST_EMR2      = 4'd4,
    ST_EMR3      = 4'd5,
    ST_EMR1      = 4'd6,
    ST_MR_DLLRST = 4'd7,
    ST_PRE2      = 4'd8,
    ST_REF1      = 4'd9,
    ST_REF2      = 4'd10,
    ST_MR        = 4'd11,
    ST_OCD_DEF   = 4'd12,
    ST_OCD_EXIT  = 4'd13,
    ST_DLL_WAIT  = 4'd14,
    ST_DONE      = 4'd15
  } state_e;

  // Command encodings as {cs_n, ras_n, cas_n, we_n}.
  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  // Bank selects for the mode / extended mode registers.
  localparam logic [2:0] BA_MR   = 3'd0;
  localparam logic [2:0] BA_EMR1 = 3'd1;
  localparam logic [2:0] BA_EMR2 = 3'd2;
  localparam logic [2:0] BA_EMR3 = 3'd3;

  // Address bit positions: A8 = DLL reset, A10 = precharge-all, A9:A7 = OCD.
  localparam int A8_BIT   = 8;
  localparam int A10_BIT  = 10;
  localparam int A9_7_LSB = 7;

  // States whose duration is governed by the command-spacing timer.
  function automatic logic is_timed(state_e s);
    return (s >= ST_PWRUP) && (s <= ST_OCD_EXIT);
  endfunction

endpackage

// File: rtl/ddr2_init_timer.sv
// Load/decrement counter used to space init commands; expired when it reaches 0.
module ddr2_init_timer #(
  parameter int CNT_WIDTH = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] load_val_i,
  output logic                 expired_o
);

  logic [CNT_WIDTH-1:0] cnt_q;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ddr2_init_sequencer.sv
// DDR2 power-up and JEDEC initialization sequencer; owns the command bus until init_done.
module ddr2_init_sequencer
  import ddr2_init_pkg::*;
#(
  parameter int                    T_PWRUP    = 66700,
  parameter int                    T_CKE      = 134,
  parameter int                    T_RP       = 5,
  parameter int                    T_MRD      = 2,
  parameter int                    T_RFC      = 43,
  parameter int                    T_DLL      = 200,
  parameter int                    CNT_WIDTH  = 17,
  parameter int                    ROW_WIDTH  = 14,
  parameter int                    BANK_WIDTH = 3,
  parameter logic [ROW_WIDTH-1:0]  MR_VALUE   = 14'h0432,
  parameter logic [ROW_WIDTH-1:0]  EMR_VALUE  = 14'h0004
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ck_en,
  output logic                  ddr_cke,
  output logic                  ddr_cs_n,
  output logic                  ddr_ras_n,
  output logic                  ddr_cas_n,
  output logic                  ddr_we_n,
  output logic [BANK_WIDTH-1:0] ddr_ba,
  output logic [ROW_WIDTH-1:0]  ddr_addr,
  output logic                  ddr_odt,
  output logic                  init_done
);

  localparam logic [ROW_WIDTH-1:0] ONE_ROW  = {{(ROW_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ROW_WIDTH-1:0] A8_MASK  = ONE_ROW << A8_BIT;
  localparam logic [ROW_WIDTH-1:0] A10_MASK = ONE_ROW << A10_BIT;
  localparam logic [ROW_WIDTH-1:0] OCD_MASK = {{(ROW_WIDTH-3){1'b0}}, 3'b111} << A9_7_LSB;
  localparam logic [CNT_WIDTH-1:0] DLL_TGT  = CNT_WIDTH'(T_DLL);

  state_e                state_q;
  logic                  ck_en_q;
  logic                  cke_q;
  logic [3:0]            cmd_q;
  logic [BANK_WIDTH-1:0] ba_q;
  logic [ROW_WIDTH-1:0]  addr_q;
  logic                  odt_q;
  logic                  done_q;
  logic [CNT_WIDTH-1:0]  dll_cnt_q;

  state_e                succ_s;
  logic                  adv_s;
  logic                  load_s;
  logic [CNT_WIDTH-1:0]  load_val_s;
  logic                  tmr_expired_s;
  logic                  dll_done_s;

  // Timer reload value (W-1) for the state being entered.
  function automatic logic [CNT_WIDTH-1:0] wait_m1(state_e s);
    case (s)
      ST_PWRUP:                         wait_m1 = CNT_WIDTH'(T_PWRUP - 1);
      ST_CKE_WAIT:                      wait_m1 = CNT_WIDTH'(T_CKE - 1);
      ST_PRE1, ST_PRE2:                 wait_m1 = CNT_WIDTH'(T_RP - 1);
      ST_REF1, ST_REF2:                 wait_m1 = CNT_WIDTH'(T_RFC - 1);
      ST_EMR2, ST_EMR3, ST_EMR1, ST_MR_DLLRST,
      ST_MR, ST_OCD_DEF, ST_OCD_EXIT:   wait_m1 = CNT_WIDTH'(T_MRD - 1);
      default:                          wait_m1 = '0;
    endcase
  endfunction

  ddr2_init_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_s),
    .load_val_i (load_val_s),
    .expired_o  (tmr_expired_s)
  );

  assign dll_done_s = (dll_cnt_q >= DLL_TGT);

  // Successor state, advance condition and timer reload for the next state.
  always_comb begin
    succ_s = state_q;
    adv_s  = 1'b0;
    case (state_q)
      ST_RESET:     begin succ_s = ST_PWRUP;     adv_s = 1'b1;          end
      ST_PWRUP:     begin succ_s = ST_CKE_WAIT;  adv_s = tmr_expired_s; end
      ST_CKE_WAIT:  begin succ_s = ST_PRE1;      adv_s = tmr_expired_s; end
      ST_PRE1:      begin succ_s = ST_EMR2;      adv_s = tmr_expired_s; end
      ST_EMR2:      begin succ_s = ST_EMR3;      adv_s = tmr_expired_s; end
      ST_EMR3:      begin succ_s = ST_EMR1;      adv_s = tmr_expired_s; end
      ST_EMR1:      begin succ_s = ST_MR_DLLRST; adv_s = tmr_expired_s; end
      ST_MR_DLLRST: begin succ_s = ST_PRE2;      adv_s = tmr_expired_s; end
      ST_PRE2:      begin succ_s = ST_REF1;      adv_s = tmr_expired_s; end
      ST_REF1:      begin succ_s = ST_REF2;      adv_s = tmr_expired_s; end
      ST_REF2:      begin succ_s = ST_MR;        adv_s = tmr_expired_s; end
      ST_MR:        begin succ_s = ST_OCD_DEF;   adv_s = tmr_expired_s; end
      ST_OCD_DEF:   begin succ_s = ST_OCD_EXIT;  adv_s = tmr_expired_s; end
      // Skip DLL_WAIT entirely when the DLL lock time has already elapsed.
      ST_OCD_EXIT:  begin succ_s = dll_done_s ? ST_DONE : ST_DLL_WAIT; adv_s = tmr_expired_s; end
      ST_DLL_WAIT:  begin succ_s = ST_DONE;      adv_s = dll_done_s;    end
      ST_DONE:      begin succ_s = ST_DONE;      adv_s = 1'b0;          end
      default:      begin succ_s = ST_RESET;     adv_s = 1'b1;          end
    endcase
    load_s     = adv_s & is_timed(succ_s);
    load_val_s = wait_m1(succ_s);
  end

  // Sequencer FSM with registered pin outputs; commands last one cycle on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RESET;
      ck_en_q   <= 1'b0;
      cke_q     <= 1'b0;
      cmd_q     <= CMD_DESEL;
      ba_q      <= '0;
      addr_q    <= '0;
      odt_q     <= 1'b0;
      done_q    <= 1'b0;
      dll_cnt_q <= '0;
    end else begin
      odt_q <= 1'b0;
      // DLL counter: starts at 1 on the DLL-reset MRS cycle, saturates at T_DLL.
      if (adv_s && (succ_s == ST_MR_DLLRST)) begin
        dll_cnt_q <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else if ((dll_cnt_q != '0) && !dll_done_s) begin
        dll_cnt_q <= dll_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        dll_cnt_q <= dll_cnt_q;
      end
      if (adv_s) begin
        state_q <= succ_s;
        ck_en_q <= 1'b1;
        if (succ_s == ST_CKE_WAIT) cke_q  <= 1'b1;
        if (succ_s == ST_DONE)     done_q <= 1'b1;
        ba_q   <= '0;
        addr_q <= '0;
        case (succ_s)
          ST_PWRUP:          cmd_q <= CMD_DESEL;
          ST_PRE1, ST_PRE2:  begin cmd_q <= CMD_PRE; addr_q <= A10_MASK; end
          ST_REF1, ST_REF2:  cmd_q <= CMD_REF;
          ST_EMR2:           begin cmd_q <= CMD_MRS; ba_q <= BANK_WIDTH'(BA_EMR2); end
          ST_EMR3:           begin cmd_q <= CMD_MRS; ba_q <= BANK_WIDTH'(BA_EMR3); end
          ST_EMR1:           begin cmd_q <= CMD_MRS; ba_q <= BANK_WIDTH'(BA_EMR1); addr_q <= EMR_VALUE; end
          ST_MR_DLLRST:      begin cmd_q <= CMD_MRS; ba_q <= BANK_WIDTH'(BA_MR);   addr_q <= MR_VALUE | A8_MASK; end
          ST_MR:             begin cmd_q <= CMD_MRS; ba_q <= BANK_WIDTH'(BA_MR);   addr_q <= MR_VALUE & ~A8_MASK; end
          ST_OCD_DEF:        begin cmd_q <= CMD_MRS; ba_q <= BANK_WIDTH'(BA_EMR1); addr_q <= EMR_VALUE | OCD_MASK; end
          ST_OCD_EXIT:       begin cmd_q <= CMD_MRS; ba_q <= BANK_WIDTH'(BA_EMR1); addr_q <= EMR_VALUE & ~OCD_MASK; end
          ST_CKE_WAIT, ST_DLL_WAIT, ST_DONE: cmd_q <= CMD_NOP;
          default:           cmd_q <= CMD_DESEL;
        endcase
      end else begin
        // Deselect while CKE is low, NOP on every non-command cycle afterwards.
        cmd_q  <= ((state_q == ST_RESET) || (state_q == ST_PWRUP)) ? CMD_DESEL : CMD_NOP;
        ba_q   <= '0;
        addr_q <= '0;
      end
    end
  end

  assign ck_en     = ck_en_q;
  assign ddr_cke   = cke_q;
  assign ddr_cs_n  = cmd_q[3];
  assign ddr_ras_n = cmd_q[2];
  assign ddr_cas_n = cmd_q[1];
  assign ddr_we_n  = cmd_q[0];
  assign ddr_ba    = ba_q;
  assign ddr_addr  = addr_q;
  assign ddr_odt   = odt_q;
  assign init_done = done_q;

endmodule

// File: tb/tb_ddr2_init_sequencer.sv
// Scoreboard bench for ddr2_init_sequencer: spec-level command schedule, random reset pulses.
module tb_ddr2_init_sequencer;

  localparam int P_PWRUP = 20;
  localparam int P_CKE   = 8;
  localparam int P_RP    = 3;
  localparam int P_MRD   = 2;
  localparam int P_RFC   = 10;
  localparam int P_DLL   = 40;
  localparam int P_DLL2  = 10;
  localparam logic [13:0] MRV  = 14'h0432;
  localparam logic [13:0] EMRV = 14'h0004;

  logic clk, rst_n;
  logic ck_en, cke, cs_n, ras_n, cas_n, we_n, odt, done;
  logic [2:0] ba;
  logic [13:0] addr;
  logic ck_en2, cke2, cs_n2, ras_n2, cas_n2, we_n2, odt2, done2;
  logic [2:0] ba2;
  logic [13:0] addr2;

  typedef struct {
    int          cyc;
    logic [3:0]  cmd;
    logic [2:0]  ba;
    logic [13:0] addr;
    logic [20:0] mask;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_done1 = 1000000;
  int   exp_done2 = 1000000;
  int   cyc = 0;
  logic in_reset = 1'b1;

  ddr2_init_sequencer #(
    .T_PWRUP(P_PWRUP), .T_CKE(P_CKE), .T_RP(P_RP), .T_MRD(P_MRD),
    .T_RFC(P_RFC), .T_DLL(P_DLL), .CNT_WIDTH(17), .ROW_WIDTH(14),
    .BANK_WIDTH(3), .MR_VALUE(MRV), .EMR_VALUE(EMRV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ck_en(ck_en), .ddr_cke(cke),
    .ddr_cs_n(cs_n), .ddr_ras_n(ras_n), .ddr_cas_n(cas_n), .ddr_we_n(we_n),
    .ddr_ba(ba), .ddr_addr(addr), .ddr_odt(odt), .init_done(done)
  );

  ddr2_init_sequencer #(
    .T_PWRUP(P_PWRUP), .T_CKE(P_CKE), .T_RP(P_RP), .T_MRD(P_MRD),
    .T_RFC(P_RFC), .T_DLL(P_DLL2), .CNT_WIDTH(17), .ROW_WIDTH(14),
    .BANK_WIDTH(3), .MR_VALUE(MRV), .EMR_VALUE(EMRV)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .ck_en(ck_en2), .ddr_cke(cke2),
    .ddr_cs_n(cs_n2), .ddr_ras_n(ras_n2), .ddr_cas_n(cas_n2), .ddr_we_n(we_n2),
    .ddr_ba(ba2), .ddr_addr(addr2), .ddr_odt(odt2), .init_done(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Reference schedule: command list with spec waits, cumulative cycle offsets.
  task automatic push_sequence();
    logic [3:0]  cmds  [0:10];
    logic [2:0]  bas   [0:10];
    logic [13:0] addrs [0:10];
    int          waits [0:10];
    int          c;
    int          dll_start;
    exp_t        e;
    cmds  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010,
              4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    bas   = '{3'd0, 3'd2, 3'd3, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
    addrs = '{14'h0400, 14'h0000, 14'h0000, EMRV, MRV | 14'h0100, 14'h0400,
              14'h0000, 14'h0000, MRV & ~14'h0100, EMRV | 14'h0380, EMRV & ~14'h0380};
    waits = '{P_RP, P_MRD, P_MRD, P_MRD, P_MRD, P_RP, P_RFC, P_RFC, P_MRD, P_MRD, P_MRD};
    c = 1 + P_PWRUP + P_CKE;
    dll_start = 0;
    for (int i = 0; i < 11; i++) begin
      e.cyc  = c;
      e.cmd  = cmds[i];
      e.ba   = bas[i];
      e.addr = addrs[i];
      if (cmds[i] == 4'b0000)      e.mask = 21'h1FFFFF;
      else if (cmds[i] == 4'b0010) e.mask = {4'hF, 3'b000, 14'h0400};
      else                         e.mask = {4'hF, 17'h0};
      sb_q.push_back(e);
      if (i == 4) dll_start = c;
      c += waits[i];
    end
    exp_done1 = (c > dll_start + P_DLL)  ? c : dll_start + P_DLL;
    exp_done2 = (c > dll_start + P_DLL2) ? c : dll_start + P_DLL2;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic go_reset();
    rst_n = 1'b0;
    sb_q.delete();
  endtask

  task automatic go_release();
    rst_n = 1'b1;
    push_sequence();
  endtask

  // Monitor: sample on the falling edge, compare against the scoreboard and level rules.
  always @(negedge clk) begin : monitor
    logic [3:0] act_cmd;
    logic [3:0] act_cmd2;
    logic [3:0] base;
    logic       act_is_cmd;
    logic       exp_is_cmd;
    exp_t       e;
    act_cmd  = {cs_n, ras_n, cas_n, we_n};
    act_cmd2 = {cs_n2, ras_n2, cas_n2, we_n2};
    if (!rst_n) begin
      in_reset = 1'b1;
      chk("reset_state", {11'd0, act_cmd, ck_en, cke, odt, done, ba, addr},
          {11'd0, 4'b1111, 4'b0000, 3'd0, 14'd0});
      chk("reset_state2", {11'd0, act_cmd2, ck_en2, cke2, odt2, done2, ba2, addr2},
          {11'd0, 4'b1111, 4'b0000, 3'd0, 14'd0});
    end else begin
      if (in_reset) cyc = 0;
      else          cyc++;
      in_reset = 1'b0;
      chk("levels", {24'd0, ck_en, cke, odt, done, ck_en2, cke2, odt2, done2},
          {24'd0, cyc >= 1, cyc >= 1 + P_PWRUP, 1'b0, cyc >= exp_done1,
           cyc >= 1, cyc >= 1 + P_PWRUP, 1'b0, cyc >= exp_done2});
      act_is_cmd = !cs_n && (act_cmd != 4'b0111);
      exp_is_cmd = (sb_q.size() > 0) && (sb_q[0].cyc == cyc);
      base       = (cyc >= 1 + P_PWRUP) ? 4'b0111 : 4'b1111;
      chk("cmd_present", {31'd0, act_is_cmd}, {31'd0, exp_is_cmd});
      if (exp_is_cmd) begin
        e = sb_q.pop_front();
        if (act_is_cmd)
          chk("cmd_fields", {11'd0, {act_cmd, ba, addr} & e.mask},
              {11'd0, {e.cmd, e.ba, e.addr} & e.mask});
        chk("dut2_cmd", {28'd0, act_cmd2}, {28'd0, e.cmd});
      end else begin
        if (!act_is_cmd) chk("idle_cmd", {28'd0, act_cmd}, {28'd0, base});
        chk("dut2_cmd", {28'd0, act_cmd2}, {28'd0, base});
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    // Full sequence from a clean reset release.
    step(3);
    go_release();
    step(90);
    // Reset pulse in the middle of the refresh phase, then a clean rerun.
    go_reset();
    step(2);
    go_release();
    step(55);
    go_reset();
    step(1);
    go_release();
    step(90);
    // Random reset points and hold lengths.
    for (int r = 0; r < 4; r++) begin
      step($urandom_range(1, 85));
      go_reset();
      step($urandom_range(1, 3));
      go_release();
    end
    // Final run through init_done and a long steady-state window.
    step(80 + 1000);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
